// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit non-show-ahead FIFO and sends each byte as an LSB-first UART frame.
// Define UART_PARITY_EN for 8E1 framing; otherwise frames are 8N1.
module fifo_uart_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_empty,
    input  logic [7:0] i_q,
    output logic       o_rdreq,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_byte_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd6;
`endif

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_rdreq;
    logic             r_busy;
    logic             r_byte_done;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_bit_end;
    logic             w_tx_nxt;
`ifdef UART_PARITY_EN
    logic             r_parity;
    logic             w_parity_nxt;
`endif

    always_comb begin
        w_bit_end   = (r_cnt == CNT_LAST);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
`ifdef UART_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!i_empty) w_state_nxt = S_READ;
            end
            S_READ: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_shift_nxt = i_q;
                w_state_nxt = S_START;
`ifdef UART_PARITY_EN
                w_parity_nxt = ^i_q;
`endif
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Line level follows the state being entered, so tx stays registered and aligned.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
`ifdef UART_PARITY_EN
            S_PARITY: w_tx_nxt = w_parity_nxt;
`endif
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
            r_rdreq     <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_tx        <= w_tx_nxt;
            r_rdreq     <= (r_state == S_IDLE) && !i_empty;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_byte_done <= (w_state_nxt == S_STOP) && (w_cnt_nxt == CNT_LAST);
`ifdef UART_PARITY_EN
            r_parity    <= w_parity_nxt;
`endif
        end
    end

    assign o_tx        = r_tx;
    assign o_rdreq     = r_rdreq;
    assign o_busy      = r_busy;
    assign o_byte_done = r_byte_done;
endmodule
